spi_txn_scheduler: RTL and testbench
====================================

Name: spi_txn_scheduler

Overview:
Transaction-level controller for the ADXL accelerometer SPI link. After reset it issues a fixed power-up configuration sequence as chip-select-framed byte transactions. It then polls X/Y/Z data registers at a programmable rate. It drives a byte-level SPI engine (PISO/SIPO plus sclk) through a start/done handshake, owns CS framing and timing, and presents captured samples to downstream logic.

Parameters:
POLL_DIV, 5000, clk cycles between poll requests; minimum 64.
CS_SETUP, 2, clk cycles from cs low to first byte_start; minimum 1.
CS_HOLD, 2, clk cycles from last byte_done to cs high; minimum 1.
CS_GAP, 4, minimum clk cycles cs stays high between transactions; minimum 1.
TIMEOUT, 255, watchdog limit in clk cycles per byte; used only with the optional feature.

Ports:
clk  input  1  system clock; all logic is on its rising edge
rst  input  1  asynchronous, active-high reset
enable  input  1  level; scheduler may start new transactions while high
byte_busy  input  1  engine is shifting a byte
byte_done  input  1  one-cycle pulse; byte_rx is valid in the same cycle
byte_rx  input  8  byte received from MISO
byte_start  output  1  one-cycle pulse requesting a byte transfer
byte_tx  output  8  byte to send; valid when byte_start=1
cs  output  1  chip select, active low
init_done  output  1  high once the config sequence completes; sticky until rst
sample_x, sample_y, sample_z  output  8 each  last captured sample
sample_valid  output  1  one-cycle pulse when all three sample registers update together
overrun  output  1  sticky; a poll tick arrived while a poll was still pending
error  output  1  sticky watchdog flag; tied to 0 when the optional feature is excluded

Behaviour:
- Reset values:
  - cs=1, byte_start=0, byte_tx=0x00.
  - init_done=0, sample_x/y/z=0x00, sample_valid=0, overrun=0, error=0.
  - Poll counter=0, FSM=IDLE.
- Config ROM, sent in order as three separate CS frames: {0x0A,0x2D,0x02}, {0x0B,0x08,0x00}, {0x0A,0x1F,0x52}. Received bytes during config are discarded.
- Poll frame: {0x0B,0x08,0x00,0x00,0x00}. The byte_rx of bytes 3, 4 and 5 loads X, Y and Z respectively.
  - Outputs update only after the frame's final byte_done.
  - sample_valid pulses in the cycle after that final byte_done.
- FSM states: IDLE -> SETUP -> START -> WAIT -> (START | HOLD) -> GAP -> IDLE.
  - IDLE: if enable=1 and config is not finished, begin the next config frame. Else if enable=1 and a poll is pending, begin a poll frame and clear pending. Otherwise stay.
  - SETUP: cs=0; wait CS_SETUP cycles.
  - START: once byte_busy=0, drive byte_start=1 for one cycle with byte_tx = current byte, then go to WAIT.
  - WAIT: hold until byte_done. Then capture if required, advance the byte index, and go to START if bytes remain, else HOLD.
  - HOLD: cs stays 0 for CS_HOLD cycles, then cs=1.
  - GAP: cs=1 for CS_GAP cycles. After the third config frame, init_done is set on GAP entry.
- Byte index is 3 bits and resets at every frame start. The frame length is 3 or 5, fixed per frame type.
- Poll timer:
  - Free-running 0..POLL_DIV-1 with wrap. Counts only while init_done=1; held at 0 otherwise.
  - At terminal count it sets pending. If pending is already 1, overrun is set instead and pending stays 1.
- enable deasserted mid-frame: the current frame completes in full, including HOLD and GAP, then the FSM stays in IDLE. Pending and the timer keep running. Re-enable resumes polling; config is never repeated except after rst.
- byte_done outside WAIT is ignored.
- rst asserted at any time returns everything to reset values immediately, including cs=1 asynchronously.
- Exactly one byte_start is issued per byte; byte_start is never asserted while byte_busy=1.

Optional Feature:
SPI_TXN_SCHEDULER_TIMEOUT_EN
- Defined:
  - An 8+ bit watchdog counts cycles in START+WAIT for the current byte.
  - On reaching TIMEOUT, the frame aborts: go to HOLD with CS_HOLD honoured, then GAP.
  - error is set sticky, and no sample_valid is generated for that frame.
  - An aborted config frame is retried from byte 0 on the next IDLE pass.
- Undefined: no watchdog; WAIT waits indefinitely; error is tied to 0.

Test Plan:
- Reset release, engine model returns byte_done 8 cycles after each start -> three CS frames with byte_tx sequences 0A 2D 02 / 0B 08 00 / 0A 1F 52; cs high ≥CS_GAP between frames; init_done rises after the third frame.
- POLL_DIV=64 after init, engine returns rx 0x11,0x22,0x33,0x44,0x55 -> poll frame 0B 08 00 00 00; sample_x=0x33, y=0x44, z=0x55; sample_valid pulses once; next frame starts 64 cycles after the previous tick.
- Engine stalls byte_done for >2×POLL_DIV cycles, feature off -> overrun=1, cs held low, no extra byte_start pulses.
- enable dropped during byte 2 of a poll -> frame completes, sample_valid pulses, cs=1; no new frame until enable=1; config not repeated.
- rst pulsed mid-WAIT -> cs=1 the same cycle; all outputs at reset values; config restarts from frame 0 after release.
- Feature on, TIMEOUT=20, engine never returns byte_done on config frame 1 byte 0 -> error=1, cs high after CS_HOLD, frame 1 retried from 0x0B.

Source files
------------

// File: rtl/spi_txn_scheduler.sv
// spi_txn_scheduler: CS-framed ADXL config sequence then periodic X/Y/Z polling over a byte SPI engine.
// Optional watchdog with frame abort: define SPI_TXN_SCHEDULER_TIMEOUT_EN.
module spi_txn_scheduler #(
  parameter int POLL_DIV = 5000,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       byte_busy,
  input  logic       byte_done,
  input  logic [7:0] byte_rx,
  output logic       byte_start,
  output logic [7:0] byte_tx,
  output logic       cs,
  output logic       init_done,
  output logic [7:0] sample_x,
  output logic [7:0] sample_y,
  output logic [7:0] sample_z,
  output logic       sample_valid,
  output logic       overrun,
  output logic       error
);
  localparam int PW = $clog2(POLL_DIV);
  typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, HOLD, GAP} state_t;
  if (POLL_DIV < 64 || CS_SETUP < 1 || CS_HOLD < 1 || CS_GAP < 1 || TIMEOUT < 1) begin : g_param_check
    $error("spi_txn_scheduler: parameter below its minimum");
  end
  state_t          state;
  logic [15:0]     cnt;
  logic [2:0]      idx;
  logic [1:0]      cfg;
  logic            poll, pending, tick, take, last, abort;
  logic [PW-1:0]   poll_cnt;
  logic [7:0]      tmp_x, tmp_y, cur;
  always_comb begin
    tick = init_done && poll_cnt == PW'(POLL_DIV - 1);
    take = state == IDLE && enable && init_done && pending;
    last = idx == (poll ? 3'd4 : 3'd2);
    cur  = poll     ? (idx == 3'd0 ? 8'h0B : idx == 3'd1 ? 8'h08 : 8'h00)
         : cfg == 0 ? (idx == 3'd0 ? 8'h0A : idx == 3'd1 ? 8'h2D : 8'h02)
         : cfg == 1 ? (idx == 3'd0 ? 8'h0B : idx == 3'd1 ? 8'h08 : 8'h00)
         :            (idx == 3'd0 ? 8'h0A : idx == 3'd1 ? 8'h1F : 8'h52);
  end
`ifdef SPI_TXN_SCHEDULER_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1) < 8 ? 8 : $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd;
`else
  assign abort = 1'b0;
  assign error = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      cfg <= '0;
      poll <= 1'b0;
      pending <= 1'b0;
      poll_cnt <= '0;
      tmp_x <= '0;
      tmp_y <= '0;
      cs <= 1'b1;
      byte_start <= 1'b0;
      byte_tx <= '0;
      init_done <= 1'b0;
      sample_x <= '0;
      sample_y <= '0;
      sample_z <= '0;
      sample_valid <= 1'b0;
      overrun <= 1'b0;
`ifdef SPI_TXN_SCHEDULER_TIMEOUT_EN
      wd <= '0;
      abort <= 1'b0;
      error <= 1'b0;
`endif
    end else begin
      byte_start <= 1'b0;
      sample_valid <= 1'b0;
      poll_cnt <= !init_done || tick ? '0 : poll_cnt + 1'b1;
      // A tick landing on the cycle the pending poll is consumed is not an overrun
      if (tick) begin
        pending <= 1'b1;
        if (pending && !take) overrun <= 1'b1;
      end else if (take) pending <= 1'b0;
      case (state)
        IDLE: if (enable && (!init_done || pending)) begin
          state <= SETUP;
          cs <= 1'b0;
          cnt <= '0;
          idx <= '0;
          poll <= init_done;
`ifdef SPI_TXN_SCHEDULER_TIMEOUT_EN
          abort <= 1'b0;
`endif
        end
        SETUP: if (cnt == 16'(CS_SETUP - 1)) state <= START;
               else cnt <= cnt + 1'b1;
        START: if (!byte_busy) begin
          byte_start <= 1'b1;
          byte_tx <= cur;
          state <= WAIT;
        end
        WAIT: if (byte_done) begin
          if (poll && idx == 3'd2) tmp_x <= byte_rx;
          if (poll && idx == 3'd3) tmp_y <= byte_rx;
          if (poll && last) begin
            sample_x <= tmp_x;
            sample_y <= tmp_y;
            sample_z <= byte_rx;
            sample_valid <= 1'b1;
          end
          idx <= idx + 1'b1;
          state <= last ? HOLD : START;
          cnt <= '0;
        end
        HOLD: if (cnt == 16'(CS_HOLD - 1)) begin
          cs <= 1'b1;
          state <= GAP;
          cnt <= '0;
          if (!poll && !abort) begin
            cfg <= cfg + 1'b1;
            if (cfg == 2'd2) init_done <= 1'b1;
          end
        end else cnt <= cnt + 1'b1;
        GAP: if (cnt == 16'(CS_GAP - 1)) state <= IDLE;
             else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
`ifdef SPI_TXN_SCHEDULER_TIMEOUT_EN
      // Watchdog overrides the case above; progress on this cycle wins over a timeout
      if (state != START && state != WAIT) wd <= '0;
      else if (state == WAIT && byte_done) wd <= '0;
      else if (wd >= WW'(TIMEOUT - 1) && !(state == START && !byte_busy)) begin
        state <= HOLD;
        cnt <= '0;
        abort <= 1'b1;
        error <= 1'b1;
      end else wd <= wd + 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_spi_txn_scheduler.sv
// tb_spi_txn_scheduler: directed bench with a byte-engine model; runs the watchdog scenario when SPI_TXN_SCHEDULER_TIMEOUT_EN is defined.
module tb_spi_txn_scheduler;
  localparam int POLL_DIV = 64;
  localparam int CS_GAP = 4;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, byte_busy = 1'b0, byte_done = 1'b0;
  logic [7:0] byte_rx = 8'h00;
  logic byte_start, cs, init_done, sample_valid, overrun, error;
  logic [7:0] byte_tx, sample_x, sample_y, sample_z;
  always #5 clk = ~clk;
  spi_txn_scheduler #(.POLL_DIV(POLL_DIV), .CS_SETUP(2), .CS_HOLD(2), .CS_GAP(CS_GAP), .TIMEOUT(20)) dut (
    .clk(clk), .rst(rst), .enable(enable), .byte_busy(byte_busy), .byte_done(byte_done),
    .byte_rx(byte_rx), .byte_start(byte_start), .byte_tx(byte_tx), .cs(cs),
    .init_done(init_done), .sample_x(sample_x), .sample_y(sample_y), .sample_z(sample_z),
    .sample_valid(sample_valid), .overrun(overrun), .error(error));
  int n_cmp = 0, n_bad = 0;
  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  logic [7:0] tx_log [0:255];
  int n_tx = 0, cnt_m = 0, stall_at = -1, fb = 0, n_frames = 0, n_sv = 0, viol = 0;
  int hi_run = 0, min_gap = 1000, last_len = 0, cyc = 0, prev_fall = 0, last_fall = 0;
  bit stall = 0, stuck = 0;
  logic cs_q = 1'b1;
  // Engine model (done 8 cycles after each start, rx = 0x11 * byte number) plus frame monitors
  always @(negedge clk) begin
    cyc++;
    byte_done = 1'b0;
    if (cs_q && !cs) begin
      n_frames++;
      fb = 0;
      prev_fall = last_fall;
      last_fall = cyc;
      if (n_frames > 1 && hi_run < min_gap) min_gap = hi_run;
    end
    if (!cs_q && cs) last_len = fb;
    hi_run = cs ? hi_run + 1 : 0;
    if (sample_valid) n_sv++;
    cs_q = cs;
    if (rst || cs) begin
      byte_busy = 1'b0;
      cnt_m = 0;
      stuck = 0;
    end else if (byte_start) begin
      if (byte_busy) viol++;
      tx_log[n_tx] = byte_tx;
      stuck = (n_tx == stall_at);
      n_tx++;
      fb++;
      byte_busy = 1'b1;
      cnt_m = 8;
    end else if (byte_busy && !stall && !stuck) begin
      cnt_m--;
      if (cnt_m == 0) begin
        byte_done = 1'b1;
        byte_rx = 8'(8'h11 * fb);
        byte_busy = 1'b0;
      end
    end
  end
  function automatic logic [79:0] seq_of(input int a, input int b);
    logic [79:0] s = '0;
    for (int i = a; i < b; i++) s = {s[71:0], tx_log[i]};
    return s;
  endfunction
  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end
  initial begin
    int n0, sv0, f0, nt;
    repeat (3) @(negedge clk);
    check("rst_cs", cs, 1);
    check("rst_byte_start", byte_start, 0);
    check("rst_byte_tx", byte_tx, 0);
    check("rst_init_done", init_done, 0);
    check("rst_samples", {sample_x, sample_y, sample_z}, 0);
    check("rst_sample_valid", sample_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_error", error, 0);
`ifdef SPI_TXN_SCHEDULER_TIMEOUT_EN
    stall_at = 3;
`endif
    rst = 1'b0;
    enable = 1'b1;
`ifdef SPI_TXN_SCHEDULER_TIMEOUT_EN
    for (int i = 0; i < 2000 && !error; i++) @(negedge clk);
    check("wd_error", error, 1);
    check("wd_cs_hold_a", cs, 0);
    @(negedge clk);
    check("wd_cs_hold_b", cs, 0);
    @(negedge clk);
    check("wd_cs_release", cs, 1);
    check("wd_no_init_yet", init_done, 0);
`endif
    for (int i = 0; i < 3000 && !init_done; i++) @(negedge clk);
    check("init_wait", init_done, 1);
`ifdef SPI_TXN_SCHEDULER_TIMEOUT_EN
    check("cfg_bytes_n", n_tx, 10);
    check("cfg_seq", seq_of(0, n_tx), 80'h0A2D020B0B08000A1F52);
    check("cfg_frames", n_frames, 4);
`else
    check("cfg_bytes_n", n_tx, 9);
    check("cfg_seq", seq_of(0, n_tx), 80'h0A2D020B08000A1F52);
    check("cfg_frames", n_frames, 3);
`endif
    check("cfg_min_gap_ok", min_gap >= CS_GAP, 1);
    for (int i = 0; i < 300 && !sample_valid; i++) @(negedge clk);
    check("poll_sv_wait", sample_valid, 1);
    check("poll_samples", {sample_x, sample_y, sample_z}, 24'h334455);
    check("poll_seq", seq_of(n_tx - 5, n_tx), 40'h0B08000000);
    check("poll_len_gap_state", init_done, 1);
    @(negedge clk);
    check("poll_sv_one_pulse", sample_valid, 0);
    f0 = n_frames;
    for (int i = 0; i < 100 && n_frames == f0; i++) @(negedge clk);
    check("poll_next_frame", n_frames, f0 + 1);
    check("poll_interval", last_fall - prev_fall, POLL_DIV);
`ifndef SPI_TXN_SCHEDULER_TIMEOUT_EN
    stall = 1;
    n0 = n_tx;
    repeat (2 * POLL_DIV + 20) @(negedge clk);
    check("stall_overrun", overrun, 1);
    check("stall_cs_low", cs, 0);
    check("stall_one_start", n_tx - n0, 1);
    check("stall_no_error", error, 0);
    stall = 0;
    for (int i = 0; i < 200 && !sample_valid; i++) @(negedge clk);
    check("stall_recover_sv", sample_valid, 1);
`endif
    f0 = n_frames;
    for (int i = 0; i < 200 && n_frames == f0; i++) @(negedge clk);
    check("en_frame_start", n_frames, f0 + 1);
    n0 = n_tx;
    for (int i = 0; i < 100 && n_tx < n0 + 2; i++) @(negedge clk);
    check("en_byte2", n_tx, n0 + 2);
    enable = 1'b0;
    sv0 = n_sv;
    for (int i = 0; i < 200 && !cs; i++) @(negedge clk);
    check("en_frame_end_cs", cs, 1);
    check("en_sv_pulse", n_sv - sv0, 1);
    check("en_frame_len", last_len, 5);
    f0 = n_frames;
    repeat (200) @(negedge clk);
    check("en_idle_no_frame", n_frames, f0);
    check("en_idle_cs", cs, 1);
    check("en_samples", {sample_x, sample_y, sample_z}, 24'h334455);
    enable = 1'b1;
    nt = n_tx;
    for (int i = 0; i < 50 && n_frames == f0; i++) @(negedge clk);
    check("re_en_frame", n_frames, f0 + 1);
    for (int i = 0; i < 200 && !cs; i++) @(negedge clk);
    check("re_en_first_byte", tx_log[nt], 8'h0B);
    check("re_en_poll_len", last_len, 5);
    check("no_busy_violation", viol, 0);
    for (int i = 0; i < 100 && !byte_busy; i++) @(negedge clk);
    check("rst_mid_busy", byte_busy, 1);
    repeat (3) @(negedge clk);
    check("rst_mid_cs_before", cs, 0);
    rst = 1'b1;
    #1;
    check("rst_async_cs", cs, 1);
    @(negedge clk);
    check("rst2_init_done", init_done, 0);
    check("rst2_samples", {sample_x, sample_y, sample_z}, 0);
    check("rst2_flags", {sample_valid, overrun, error, byte_start}, 0);
    check("rst2_byte_tx", byte_tx, 0);
    rst = 1'b0;
    n0 = n_tx;
    for (int i = 0; i < 3000 && !init_done; i++) @(negedge clk);
    check("rst2_init_wait", init_done, 1);
    check("rst2_cfg_n", n_tx - n0, 9);
    check("rst2_cfg_seq", seq_of(n0, n_tx), 72'h0A2D020B08000A1F52);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
